// File: rtl/trace_order_monitor.sv
// trace_order_monitor
//
// Taps the same character stream that feeds cpu_checker and captures the
// decimal time field of each record ("^<time>@"). When cpu_checker reports a
// finished record through format_type, the record is committed as a register
// record (1) or a memory record (2). Format code 3 is handled like 0. The block
// keeps a count of each record type and checks that committed times never go
// backwards.
//
// Configuration macro:
//   TRACE_ORDER_STRICT_EN - when defined, a committed time equal to the
//                           previous one also counts as an order violation.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   char         ASCII character, sampled on every edge
//   format_type  record classification from cpu_checker
//   reg_cnt      committed register records (saturating)
//   mem_cnt      committed memory records (saturating)
//   last_time    time of the most recent committed record that had a valid time
//   order_err    sticky flag, set by the first time-order violation
//   err_time     offending time captured at the first violation
//   time_ovf     sticky flag, set when a time field saturated
//   dbg_state_o  current capture FSM state, for observation only
//
// Handshake: there is no valid/ready pair. Every edge with reset==1 consumes
// one character, and format_type 1 or 2 at an edge is a single-cycle commit
// strobe. Every registered output shows the effect one cycle after the edge
// that sampled the cause.

module trace_order_monitor #(
  parameter int CNT_W  = 16,
  parameter int TIME_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [1:0]        format_type,
  output logic [CNT_W-1:0]  reg_cnt,
  output logic [CNT_W-1:0]  mem_cnt,
  output logic [TIME_W-1:0] last_time,
  output logic              order_err,
  output logic [TIME_W-1:0] err_time,
  output logic              time_ovf,
  output logic [1:0]        dbg_state_o
);

  localparam int EXT_W = TIME_W + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TIME = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [TIME_W-1:0] acc_q, acc_d;
  logic [3:0]        ndig_q, ndig_d;
  logic [TIME_W-1:0] pend_time_q, pend_time_d;
  logic              pend_valid_q, pend_valid_d;
  logic              have_last_q, have_last_d;
  logic [CNT_W-1:0]  reg_cnt_q, reg_cnt_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic              order_err_q, order_err_d;
  logic [TIME_W-1:0] err_time_q, err_time_d;
  logic              time_ovf_q, time_ovf_d;

  // Character decode
  logic is_caret, is_at, is_digit;
  assign is_caret = (char == 8'h5E);
  assign is_at    = (char == 8'h40);
  assign is_digit = (char >= 8'h30) && (char <= 8'h39);

  // The wider accumulator lets the multiply-add run without wrapping, so an
  // overflow past TIME_W bits can be detected and clamped.
  logic [EXT_W-1:0] acc_ext;
  logic             acc_sat;
  assign acc_ext = ({4'b0000, acc_q} * EXT_W'(10)) + EXT_W'(char[3:0]);
  assign acc_sat = (acc_ext > {4'b0000, {TIME_W{1'b1}}});

  logic commit;
  assign commit = (format_type == 2'd1) || (format_type == 2'd2);

  logic violation;
`ifdef TRACE_ORDER_STRICT_EN
  assign violation = have_last_q && (pend_time_q <= last_time_q);
`else
  assign violation = have_last_q && (pend_time_q < last_time_q);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A caret restarts capture from any state.
  always_comb begin
    state_d = state_q;
    if (is_caret) begin
      state_d = ST_TIME;
    end else if (state_q == ST_TIME) begin
      if (is_digit) begin
        state_d = ST_TIME;
      end else if (is_at) begin
        state_d = (ndig_q != 4'd0) ? ST_DONE : ST_IDLE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    acc_d        = acc_q;
    ndig_d       = ndig_q;
    pend_time_d  = pend_time_q;
    pend_valid_d = pend_valid_q;
    have_last_d  = have_last_q;
    reg_cnt_d    = reg_cnt_q;
    mem_cnt_d    = mem_cnt_q;
    last_time_d  = last_time_q;
    order_err_d  = order_err_q;
    err_time_d   = err_time_q;
    time_ovf_d   = time_ovf_q;

    // The commit reads only the pre-edge pending values. Any capture update
    // below is applied afterwards, so a time closed by "@" on the same edge
    // stays pending for the next commit.
    if (commit) begin
      if (format_type == 2'd1) begin
        if (reg_cnt_q != {CNT_W{1'b1}}) reg_cnt_d = reg_cnt_q + CNT_W'(1);
      end else begin
        if (mem_cnt_q != {CNT_W{1'b1}}) mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end
      if (pend_valid_q) begin
        if (violation && !order_err_q) begin
          order_err_d = 1'b1;
          err_time_d  = pend_time_q;
        end
        last_time_d = pend_time_q;
        have_last_d = 1'b1;
      end
      pend_valid_d = 1'b0;
    end

    if (is_caret) begin
      acc_d        = '0;
      ndig_d       = 4'd0;
      pend_valid_d = 1'b0;
    end else if (state_q == ST_TIME) begin
      if (is_digit) begin
        if (acc_sat) begin
          acc_d      = {TIME_W{1'b1}};
          time_ovf_d = 1'b1;
        end else begin
          acc_d = acc_ext[TIME_W-1:0];
        end
        if (ndig_q != 4'hF) ndig_d = ndig_q + 4'd1;
      end else if (is_at) begin
        if (ndig_q != 4'd0) begin
          pend_time_d  = acc_q;
          pend_valid_d = 1'b1;
        end
      end else begin
        // A malformed field never becomes pending.
        pend_valid_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q        <= '0;
      ndig_q       <= 4'd0;
      pend_time_q  <= '0;
      pend_valid_q <= 1'b0;
      have_last_q  <= 1'b0;
      reg_cnt_q    <= '0;
      mem_cnt_q    <= '0;
      last_time_q  <= '0;
      order_err_q  <= 1'b0;
      err_time_q   <= '0;
      time_ovf_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      ndig_q       <= ndig_d;
      pend_time_q  <= pend_time_d;
      pend_valid_q <= pend_valid_d;
      have_last_q  <= have_last_d;
      reg_cnt_q    <= reg_cnt_d;
      mem_cnt_q    <= mem_cnt_d;
      last_time_q  <= last_time_d;
      order_err_q  <= order_err_d;
      err_time_q   <= err_time_d;
      time_ovf_q   <= time_ovf_d;
    end
  end

  assign reg_cnt     = reg_cnt_q;
  assign mem_cnt     = mem_cnt_q;
  assign last_time   = last_time_q;
  assign order_err   = order_err_q;
  assign err_time    = err_time_q;
  assign time_ovf    = time_ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trace_order_monitor.sv
module tb_trace_order_monitor;

  logic        clk;
  logic        reset;
  logic [7:0]  ch;
  logic [1:0]  ft;
  logic [15:0] reg_cnt;
  logic [15:0] mem_cnt;
  logic [31:0] last_time;
  logic        order_err;
  logic [31:0] err_time;
  logic        time_ovf;
  logic [1:0]  dbg_state;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];

`ifdef TRACE_ORDER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  trace_order_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .format_type (ft),
    .reg_cnt     (reg_cnt),
    .mem_cnt     (mem_cnt),
    .last_time   (last_time),
    .order_err   (order_err),
    .err_time    (err_time),
    .time_ovf    (time_ovf),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic send(input logic [7:0] c, input logic [1:0] f);
    ch = c;
    ft = f;
    @(posedge clk);
    #1;
    ft = 2'd0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    send(8'h20, 2'd0);
    send(8'h20, 2'd0);
    reset = 1'b1;
  endtask

  // Decimal value of the leading digits of s, clamped to 32 bits.
  function automatic longint dec_value(input string s, output bit ovf);
    longint v;
    v = 0;
    ovf = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] < 8'h30 || s[i] > 8'h39) break;
      v = v * 10 + longint'(s[i] - 8'h30);
      if (v > 64'hFFFF_FFFF) begin
        v = 64'hFFFF_FFFF;
        ovf = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    send("^", 2'd1);
    send("5", 2'd2);
    send("@", 2'd1);
    send("#", 2'd2);
    compared++; if (reg_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_reg_cnt got %0d exp 0", reg_cnt); end
    compared++; if (mem_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_mem_cnt got %0d exp 0", mem_cnt); end
    compared++; if (last_time !== 32'd0) begin mismatched++; $display("FAIL reset_last_time got %0d exp 0", last_time); end
    compared++; if (order_err !== 1'b0) begin mismatched++; $display("FAIL reset_order_err got %0b exp 0", order_err); end
    compared++; if (err_time !== 32'd0) begin mismatched++; $display("FAIL reset_err_time got %0d exp 0", err_time); end
    compared++; if (time_ovf !== 1'b0) begin mismatched++; $display("FAIL reset_time_ovf got %0b exp 0", time_ovf); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    send_str("^242@00003f44: $31 <= 12345678");
    send("#", 2'd1);
    compared++; if (reg_cnt !== 16'd1) begin mismatched++; $display("FAIL basic_reg_cnt got %0d exp 1", reg_cnt); end
    compared++; if (mem_cnt !== 16'd0) begin mismatched++; $display("FAIL basic_mem_cnt got %0d exp 0", mem_cnt); end
    compared++; if (last_time !== 32'd242) begin mismatched++; $display("FAIL basic_last_time got %0d exp 242", last_time); end
    compared++; if (order_err !== 1'b0) begin mismatched++; $display("FAIL basic_order_err got %0b exp 0", order_err); end
    send_str("^338@00003f48: *00000088 <= 0000abcd");
    send("#", 2'd2);
    compared++; if (mem_cnt !== 16'd1) begin mismatched++; $display("FAIL mem_mem_cnt got %0d exp 1", mem_cnt); end
    compared++; if (last_time !== 32'd338) begin mismatched++; $display("FAIL mem_last_time got %0d exp 338", last_time); end
    compared++; if (order_err !== 1'b0) begin mismatched++; $display("FAIL mem_order_err got %0b exp 0", order_err); end
  endtask

  // Continues from test_basic state: reg=1, mem=1, last=338.
  task automatic test_order();
    send_str("^1024@00003f4c: $2 <= 1");
    send("#", 2'd1);
    send_str("^242@00003f50: $3 <= 2");
    send("#", 2'd1);
    compared++; if (order_err !== 1'b1) begin mismatched++; $display("FAIL order_err got %0b exp 1", order_err); end
    compared++; if (err_time !== 32'd242) begin mismatched++; $display("FAIL order_err_time got %0d exp 242", err_time); end
    compared++; if (last_time !== 32'd242) begin mismatched++; $display("FAIL order_last_time got %0d exp 242", last_time); end
    compared++; if (reg_cnt !== 16'd3) begin mismatched++; $display("FAIL order_reg_cnt got %0d exp 3", reg_cnt); end
    send_str("^100@00003f54: $4 <= 3");
    send("#", 2'd1);
    compared++; if (err_time !== 32'd242) begin mismatched++; $display("FAIL order_sticky_err_time got %0d exp 242", err_time); end
    compared++; if (last_time !== 32'd100) begin mismatched++; $display("FAIL order_later_last_time got %0d exp 100", last_time); end
    compared++; if (reg_cnt !== 16'd4) begin mismatched++; $display("FAIL order_later_reg_cnt got %0d exp 4", reg_cnt); end
  endtask

  task automatic test_equal();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_str("^242@00003f44: $1 <= 7");
      send("#", 2'd1);
    end
    compared++; if (order_err !== STRICT) begin mismatched++; $display("FAIL equal_order_err got %0b exp %0b", order_err, STRICT); end
    compared++; if (err_time !== (STRICT ? 32'd242 : 32'd0)) begin mismatched++; $display("FAIL equal_err_time got %0d exp %0d", err_time, STRICT ? 242 : 0); end
    compared++; if (reg_cnt !== 16'd2) begin mismatched++; $display("FAIL equal_reg_cnt got %0d exp 2", reg_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("^99999999999@");
    compared++; if (time_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %0b exp 1", time_ovf); end
    send_str("00003f44: $1 <= 7");
    send("#", 2'd1);
    compared++; if (last_time !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL ovf_last_time got %h exp ffffffff", last_time); end
    send_str("^2a4@00003f48: $1 <= 7");
    send("#", 2'd1);
    compared++; if (last_time !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL malformed_last_time got %h exp ffffffff", last_time); end
    compared++; if (reg_cnt !== 16'd2) begin mismatched++; $display("FAIL malformed_reg_cnt got %0d exp 2", reg_cnt); end
    compared++; if (order_err !== 1'b0) begin mismatched++; $display("FAIL malformed_order_err got %0b exp 0", order_err); end
    send_str("^@x");
    send("#", 2'd2);
    compared++; if (mem_cnt !== 16'd1) begin mismatched++; $display("FAIL empty_mem_cnt got %0d exp 1", mem_cnt); end
    compared++; if (last_time !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL empty_last_time got %h exp ffffffff", last_time); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_str("^500@xx");
    send("#", 2'd1);
    send_str("^24");
    reset = 1'b0;
    send("9", 2'd1);
    reset = 1'b1;
    send_str("2@");
    send("#", 2'd1);
    compared++; if (reg_cnt !== 16'd1) begin mismatched++; $display("FAIL midreset_reg_cnt got %0d exp 1", reg_cnt); end
    compared++; if (last_time !== 32'd0) begin mismatched++; $display("FAIL midreset_last_time got %0d exp 0", last_time); end
    compared++; if (order_err !== 1'b0) begin mismatched++; $display("FAIL midreset_order_err got %0b exp 0", order_err); end
  endtask

  task automatic test_same_edge();
    do_reset();
    send_str("^500@ab");
    send("^", 2'd1);  // commits 500 and starts a new field
    compared++; if (last_time !== 32'd500) begin mismatched++; $display("FAIL caret_commit_last_time got %0d exp 500", last_time); end
    compared++; if (reg_cnt !== 16'd1) begin mismatched++; $display("FAIL caret_commit_reg_cnt got %0d exp 1", reg_cnt); end
    send_str("300@");
    send("#", 2'd2);
    compared++; if (last_time !== 32'd300) begin mismatched++; $display("FAIL caret_next_last_time got %0d exp 300", last_time); end
    compared++; if (order_err !== 1'b1) begin mismatched++; $display("FAIL caret_next_order_err got %0b exp 1", order_err); end
    compared++; if (err_time !== 32'd300) begin mismatched++; $display("FAIL caret_next_err_time got %0d exp 300", err_time); end
    send_str("^70");
    send("0", 2'd0);
    send("@", 2'd1);  // commit sees nothing pending; 700 becomes pending
    compared++; if (last_time !== 32'd300) begin mismatched++; $display("FAIL at_commit_last_time got %0d exp 300", last_time); end
    compared++; if (reg_cnt !== 16'd2) begin mismatched++; $display("FAIL at_commit_reg_cnt got %0d exp 2", reg_cnt); end
    send("#", 2'd1);
    compared++; if (last_time !== 32'd700) begin mismatched++; $display("FAIL at_next_last_time got %0d exp 700", last_time); end
    compared++; if (reg_cnt !== 16'd3) begin mismatched++; $display("FAIL at_next_reg_cnt got %0d exp 3", reg_cnt); end
  endtask

  task automatic test_random();
    longint m_last, m_err_time, base, t, v;
    bit     m_have, m_err, m_ovf, ovf, valid, commit;
    int     m_reg, m_mem, mode;
    logic [1:0]  f;
    logic [31:0] e;
    string  field;
    do_reset();
    m_last = 0; m_err_time = 0; base = 0;
    m_have = 0; m_err = 0; m_ovf = 0; m_reg = 0; m_mem = 0;
    for (int r = 0; r < 60; r++) begin
      mode = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) t = $urandom_range(0, 1000);
      else begin base += $urandom_range(0, 100); t = base; end
      field = $sformatf("%0d", t);
      if (mode == 0) field = "";
      else if (mode == 1) field = {field.substr(0, 0), "x", field.substr(1, field.len() - 1)};
      else if (mode == 2) begin
        field = $sformatf("%0d", $urandom_range(1, 9));
        for (int k = 0; k < 10; k++) field = $sformatf("%s%0d", field, $urandom_range(0, 9));
      end
      v = dec_value(field, ovf);
      valid = (field.len() > 0) && (mode != 1);
      m_ovf = m_ovf | ovf;
      f = 2'($urandom_range(0, 3));
      commit = (f == 2'd1) || (f == 2'd2);
      send("^", 2'd0);
      send_str(field);
      send_str("@00003f44: $31 <= 5");
      send("#", f);
      if (commit) begin
        if (f == 2'd1) m_reg++; else m_mem++;
        if (valid) begin
          if (m_have && !m_err && ((v < m_last) || (STRICT && v == m_last))) begin
            m_err = 1;
            m_err_time = v;
          end
          m_last = v;
          m_have = 1;
        end
      end
      exp_q.push_back(32'(m_last));
      e = exp_q.pop_front();
      compared++; if (last_time !== e) begin mismatched++; $display("FAIL rand_last_time rec %0d got %0d exp %0d", r, last_time, e); end
      compared++; if (reg_cnt !== 16'(m_reg)) begin mismatched++; $display("FAIL rand_reg_cnt rec %0d got %0d exp %0d", r, reg_cnt, m_reg); end
      compared++; if (mem_cnt !== 16'(m_mem)) begin mismatched++; $display("FAIL rand_mem_cnt rec %0d got %0d exp %0d", r, mem_cnt, m_mem); end
      compared++; if (order_err !== m_err) begin mismatched++; $display("FAIL rand_order_err rec %0d got %0b exp %0b", r, order_err, m_err); end
      compared++; if (err_time !== 32'(m_err_time)) begin mismatched++; $display("FAIL rand_err_time rec %0d got %0d exp %0d", r, err_time, m_err_time); end
      compared++; if (time_ovf !== m_ovf) begin mismatched++; $display("FAIL rand_time_ovf rec %0d got %0b exp %0b", r, time_ovf, m_ovf); end
    end
  endtask

  initial begin
    reset = 1'b0;
    ch    = 8'h20;
    ft    = 2'd0;
    test_reset();
    test_basic();
    test_order();
    test_equal();
    test_overflow();
    test_reset_mid();
    test_same_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trace_order_monitor.md
Name: trace_order_monitor

Overview:
- Sits directly downstream of cpu_checker and taps the same char stream in parallel with it.
- Independently captures the decimal time field of each record, "^<time>@".
- Uses cpu_checker's format_type result to commit a record as register-type or memory-type.
- Maintains per-type record counts and checks that committed record times never go backwards.

Parameters:
- CNT_W, 16: width of the record counters; counters saturate at all-ones.
- TIME_W, 32: width of the captured time value; the value saturates at all-ones.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; state clears at a rising clk edge while reset==0.
- char  input  8  ASCII character; the same byte presented to cpu_checker, sampled every edge.
- format_type  input  2  from cpu_checker: 0 = no record; 1 = valid register record; 2 = valid memory record; 3 = treat as 0.
- reg_cnt  output  CNT_W  count of committed register records.
- mem_cnt  output  CNT_W  count of committed memory records.
- last_time  output  TIME_W  time of the most recent committed record that had a valid time.
- order_err  output  1  sticky flag; set on the first time-order violation.
- err_time  output  TIME_W  offending time captured at the first violation.
- time_ovf  output  1  sticky flag; set when a time field saturated.

Behaviour:
- Reset (reset==0 at an edge): all outputs are 0; capture FSM goes to IDLE; pend_valid=0; have_last=0.
- All outputs are registered. Every effect appears in the cycle after the edge that sampled the causing input.
- Capture FSM states: IDLE, TIME, DONE.
  - Any state, char=="^": go to TIME; acc=0; ndig=0; pend_valid=0.
  - TIME, char is "0".."9": acc = acc*10 + digit, computed with TIME_W+4 bits. If the result exceeds 2^TIME_W-1, acc holds all-ones and time_ovf is set. ndig increments, saturating.
  - TIME, char=="@": if ndig>0, pend_time=acc, pend_valid=1, go to DONE; if ndig==0, go to IDLE.
  - TIME, any other char: go to IDLE; pend_valid=0 (malformed field).
  - DONE/IDLE, chars other than "^": ignored.
- Commit occurs at an edge where format_type is 1 or 2.
  - The matching counter increments, saturating at 2^CNT_W-1.
  - If pend_valid==1:
    - If have_last==1 and pend_time < last_time, a violation is detected. If order_err==0, set order_err=1 and err_time=pend_time. err_time is not changed by later violations.
    - last_time=pend_time; have_last=1.
  - If pend_valid==0: counter updates only; no order check; last_time is unchanged.
  - pend_valid is cleared after every commit.
- Simultaneous commit and "^" at the same edge: the commit uses the pre-edge pend_time/pend_valid, and the "^" restarts capture. Both take effect at that edge.
- Commit and "@" at the same edge: the commit uses the old pend_* values. The new time becomes pending for the next commit.
- Equal times (pend_time == last_time) are legal by default.
- reset==0 mid-record: everything clears. A following "#" or format_type pulse commits with pend_valid=0.
- Nonzero format_type while reset==0 is ignored.

Optional Feature:
- Macro: TRACE_ORDER_STRICT_EN.
- Defined: times must be strictly increasing. The violation condition becomes pend_time <= last_time.
- Undefined: the violation condition is pend_time < last_time.

Test Plan:
- Stream "^242@00003f44: $31 <= 12345678#" with format_type=1 pulsed at completion -> reg_cnt=1, mem_cnt=0, last_time=242, order_err=0.
- Then "^338@...: *00000088 <= ...#" with format_type=2 -> mem_cnt=1, last_time=338, order_err=0.
- Then "^1024@..." with format_type=1, then "^242@..." with format_type=1 -> order_err=1, err_time=242, last_time=242, reg_cnt=3. A later "^100@..." commit leaves err_time=242.
- Repeat "^242@..." twice with format_type=1 each time -> order_err=0 by default; order_err=1 and err_time=242 with TRACE_ORDER_STRICT_EN.
- Time field "^99999999999@" -> time_ovf=1, pending time=32'hFFFFFFFF. Field "^2a4@" -> pend_valid=0, and a commit leaves last_time unchanged while the counter still increments.
- Drive reset=0 mid-field after "^24", then reset=1, then "2@" and a format_type=1 pulse -> reg_cnt=1, last_time=0, order_err=0. Drive format_type=1 on the same edge as "^" -> the commit uses the old pending time.
